// File: rtl/rv_pkg.sv
// rv_pkg: constants and types shared by the RISC-V core blocks.
package rv_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] reg_idx_t;

    // One-hot decode of a register index into a 32-bit mask; x0 never selects a bit.
    function automatic logic [31:0] reg_mask(input reg_idx_t idx);
        logic [31:0] m;
        m = 32'd0;
        if (idx != 5'd0) begin
            m[idx] = 1'b1;
        end else begin
            m = 32'd0;
        end
        return m;
    endfunction

endpackage

// File: rtl/rv_scoreboard.sv
// rv_scoreboard: busy mask of registers with a write-back still outstanding.
// Bit 0 (x0) is never busy. A set and a clear of the same index in one
// cycle leaves the bit set, because the new writer is younger than the one
// completing.
module rv_scoreboard (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_set,
    input  logic [4:0] i_set_idx,
    input  logic       i_clr,
    input  logic [4:0] i_clr_idx,
    input  logic [4:0] i_idx1,
    input  logic [4:0] i_idx2,
    output logic       o_busy1,
    output logic       o_busy2
);
    import rv_pkg::*;

    logic [31:0] busy_q;
    logic [31:0] busy_d;
    logic [31:0] set_mask_s;
    logic [31:0] clr_mask_s;

    // Next busy mask: apply the clear first, then the set, so set wins; x0 kept idle.
    always_comb begin
        set_mask_s = 32'd0;
        clr_mask_s = 32'd0;
        if (i_set) begin
            set_mask_s = reg_mask(i_set_idx);
        end else begin
            set_mask_s = 32'd0;
        end
        if (i_clr) begin
            clr_mask_s = reg_mask(i_clr_idx);
        end else begin
            clr_mask_s = 32'd0;
        end
        busy_d = ((busy_q & ~clr_mask_s) | set_mask_s) & ~32'd1;
    end

    // Busy mask register, cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_busy1 = busy_q[i_idx1];
    assign o_busy2 = busy_q[i_idx2];

endmodule

// File: rtl/rv_operand_fetch.sv
// rv_operand_fetch: operand-fetch stage between decode and execute.
// Holds one instruction (S1), addresses the register file (1-cycle read
// latency), patches same-cycle write/read collisions from a registered copy
// of the write-back, and stalls on sources still busy in the scoreboard.
// Optional feature macro: RV_OPFETCH_WB_BYPASS_EN -- forward i_wb_data into
// a busy operand so the consumer issues in the write-back cycle.
module rv_operand_fetch #(
    parameter int XLEN      = rv_pkg::XLEN,
    parameter int PAYLOAD_W = 64
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [4:0]           i_rs1,
    input  logic [4:0]           i_rs2,
    input  logic                 i_use_rs1,
    input  logic                 i_use_rs2,
    input  logic [4:0]           i_rd,
    input  logic [PAYLOAD_W-1:0] i_payload,
    output logic [4:0]           o_rf_rs1,
    output logic [4:0]           o_rf_rs2,
    input  logic [XLEN-1:0]      i_rf_data1,
    input  logic [XLEN-1:0]      i_rf_data2,
    input  logic                 i_wb_write,
    input  logic [4:0]           i_wb_rd,
    input  logic [XLEN-1:0]      i_wb_data,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [XLEN-1:0]      o_op1,
    output logic [XLEN-1:0]      o_op2,
    output logic [4:0]           o_rd,
    output logic [PAYLOAD_W-1:0] o_payload
);
    import rv_pkg::*;

    logic                 s1_valid_q, s1_valid_d;
    logic [4:0]           s1_rs1_q, s1_rs1_d;
    logic [4:0]           s1_rs2_q, s1_rs2_d;
    logic                 s1_use1_q, s1_use1_d;
    logic                 s1_use2_q, s1_use2_d;
    logic [4:0]           s1_rd_q, s1_rd_d;
    logic [PAYLOAD_W-1:0] s1_payload_q, s1_payload_d;

    logic                 wbr_valid_q, wbr_valid_d;
    logic [4:0]           wbr_rd_q, wbr_rd_d;
    logic [XLEN-1:0]      wbr_data_q, wbr_data_d;

    logic                 busy1_s, busy2_s;
    logic                 byp1_s, byp2_s;
    logic                 hazard_s;
    logic                 issue_s;
    logic                 ready_s;
    logic                 accept_s;
    logic [XLEN-1:0]      op1_s, op2_s;

    // Pick the freshest value of one source: x0, live write-back, registered write-back, RF.
    function automatic logic [XLEN-1:0] resolve_op(
        input logic [4:0]      rs,
        input logic            byp,
        input logic            wbr_valid,
        input logic [4:0]      wbr_rd,
        input logic [XLEN-1:0] wbr_data,
        input logic [XLEN-1:0] wb_data,
        input logic [XLEN-1:0] rf_data
    );
        logic [XLEN-1:0] r;
        r = rf_data;
        if (rs == 5'd0) begin
            r = '0;
        end else if (byp) begin
            r = wb_data;
        end else if (wbr_valid && (wbr_rd != 5'd0) && (wbr_rd == rs)) begin
            r = wbr_data;
        end else begin
            r = rf_data;
        end
        return r;
    endfunction

    rv_scoreboard u_scoreboard (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_set     (issue_s),
        .i_set_idx (s1_rd_q),
        .i_clr     (i_wb_write),
        .i_clr_idx (i_wb_rd),
        .i_idx1    (s1_rs1_q),
        .i_idx2    (s1_rs2_q),
        .o_busy1   (busy1_s),
        .o_busy2   (busy2_s)
    );

    // Hazard, handshake and operand selection for the held instruction.
    always_comb begin
`ifdef RV_OPFETCH_WB_BYPASS_EN
        byp1_s = i_wb_write && (i_wb_rd != 5'd0) && (i_wb_rd == s1_rs1_q);
        byp2_s = i_wb_write && (i_wb_rd != 5'd0) && (i_wb_rd == s1_rs2_q);
`else
        byp1_s = 1'b0;
        byp2_s = 1'b0;
`endif
        hazard_s = (s1_use1_q && busy1_s && !byp1_s) ||
                   (s1_use2_q && busy2_s && !byp2_s);
        o_valid  = s1_valid_q && !hazard_s;
        issue_s  = o_valid && i_ready;
        ready_s  = !s1_valid_q || issue_s;
        accept_s = i_valid && ready_s;
        op1_s    = resolve_op(s1_rs1_q, byp1_s, wbr_valid_q, wbr_rd_q,
                              wbr_data_q, i_wb_data, i_rf_data1);
        op2_s    = resolve_op(s1_rs2_q, byp2_s, wbr_valid_q, wbr_rd_q,
                              wbr_data_q, i_wb_data, i_rf_data2);
    end

    // S1 next state: flush beats accept, accept refills, issue empties, else hold.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_rs1_d     = s1_rs1_q;
        s1_rs2_d     = s1_rs2_q;
        s1_use1_d    = s1_use1_q;
        s1_use2_d    = s1_use2_q;
        s1_rd_d      = s1_rd_q;
        s1_payload_d = s1_payload_q;
        if (i_flush) begin
            s1_valid_d = 1'b0;
        end else if (accept_s) begin
            s1_valid_d   = 1'b1;
            s1_rs1_d     = i_rs1;
            s1_rs2_d     = i_rs2;
            s1_use1_d    = i_use_rs1;
            s1_use2_d    = i_use_rs2;
            s1_rd_d      = i_rd;
            s1_payload_d = i_payload;
        end else if (issue_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Registered copy of this cycle's write-back, used to patch next cycle's stale RF data.
    always_comb begin
        wbr_valid_d = i_wb_write;
        wbr_rd_d    = i_wb_rd;
        wbr_data_d  = i_wb_data;
    end

    // State registers for S1 and the collision copy.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid_q   <= 1'b0;
            s1_rs1_q     <= 5'd0;
            s1_rs2_q     <= 5'd0;
            s1_use1_q    <= 1'b0;
            s1_use2_q    <= 1'b0;
            s1_rd_q      <= 5'd0;
            s1_payload_q <= '0;
            wbr_valid_q  <= 1'b0;
            wbr_rd_q     <= 5'd0;
            wbr_data_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_rs1_q     <= s1_rs1_d;
            s1_rs2_q     <= s1_rs2_d;
            s1_use1_q    <= s1_use1_d;
            s1_use2_q    <= s1_use2_d;
            s1_rd_q      <= s1_rd_d;
            s1_payload_q <= s1_payload_d;
            wbr_valid_q  <= wbr_valid_d;
            wbr_rd_q     <= wbr_rd_d;
            wbr_data_q   <= wbr_data_d;
        end
    end

    // The held instruction is re-read while stalled so its RF data stays current.
    assign o_rf_rs1  = ready_s ? i_rs1 : s1_rs1_q;
    assign o_rf_rs2  = ready_s ? i_rs2 : s1_rs2_q;
    assign o_ready   = ready_s;
    assign o_op1     = op1_s;
    assign o_op2     = op2_s;
    assign o_rd      = s1_rd_q;
    assign o_payload = s1_payload_q;

endmodule

// File: tb/tb_rv_operand_fetch.sv
// tb_rv_operand_fetch: directed bench for rv_operand_fetch with a behavioural
// register file (registered read, old data on same-cycle write).
module tb_rv_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid, o_ready;
    logic [4:0]  rs1, rs2, rd;
    logic        use1, use2;
    logic [63:0] payload;
    logic [4:0]  o_rf_rs1, o_rf_rs2;
    logic [31:0] rf_data1, rf_data2;
    logic        wb_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        o_valid;
    logic        ready;
    logic [31:0] o_op1, o_op2;
    logic [4:0]  o_rd;
    logic [63:0] o_payload;
    logic [31:0] rf [32];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv_operand_fetch #(.XLEN(32), .PAYLOAD_W(64)) dut (
        .i_clk(clk), .i_reset(reset), .i_valid(valid), .o_ready(o_ready),
        .i_rs1(rs1), .i_rs2(rs2), .i_use_rs1(use1), .i_use_rs2(use2),
        .i_rd(rd), .i_payload(payload), .o_rf_rs1(o_rf_rs1), .o_rf_rs2(o_rf_rs2),
        .i_rf_data1(rf_data1), .i_rf_data2(rf_data2), .i_wb_write(wb_write),
        .i_wb_rd(wb_rd), .i_wb_data(wb_data), .i_flush(flush), .o_valid(o_valid),
        .i_ready(ready), .o_op1(o_op1), .o_op2(o_op2), .o_rd(o_rd),
        .o_payload(o_payload)
    );

    // Register file model: 1-cycle registered read returning pre-write data.
    always @(posedge clk) begin
        rf_data1 <= (o_rf_rs1 == 5'd0) ? 32'd0 : rf[o_rf_rs1];
        rf_data2 <= (o_rf_rs2 == 5'd0) ? 32'd0 : rf[o_rf_rs2];
        if (wb_write && (wb_rd != 5'd0)) rf[wb_rd] <= wb_data;
    end

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                         input logic ua, input logic ub, input logic [4:0] d,
                         input logic [63:0] pl);
        valid = v; rs1 = a; rs2 = b; use1 = ua; use2 = ub; rd = d; payload = pl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic wbd(input logic w, input logic [4:0] d, input logic [31:0] dat);
        wb_write = w; wb_rd = d; wb_data = dat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ready = 1'b1;
        idle(); wbd(1'b0, 5'd0, 32'd0);
        tick();
        // Preload the register file through the write port while in reset.
        wbd(1'b1, 5'd5, 32'h11);   tick();
        wbd(1'b1, 5'd6, 32'h22);   tick();
        wbd(1'b1, 5'd3, 32'h3333); tick();
        wbd(1'b1, 5'd7, 32'h7777); tick();
        wbd(1'b1, 5'd9, 32'h9999); tick();
        wbd(1'b0, 5'd0, 32'd0);    tick();
        #1;
        check_vec("rst_valid", o_valid, 64'd0);
        check_vec("rst_ready", o_ready, 64'd1);
        reset = 1'b0;
        tick();
        check_vec("rst_rel_valid", o_valid, 64'd0);

        // 1: back-to-back independent ops.
        drive(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd10, 64'h1111); #1;
        check_vec("t1_ready", o_ready, 64'd1);
        check_vec("t1_rfaddr", o_rf_rs1, 64'd5);
        tick();
        drive(1'b1, 5'd6, 5'd5, 1'b1, 1'b1, 5'd11, 64'h2222); #1;
        check_vec("t1a_valid", o_valid, 64'd1);
        check_vec("t1a_op1", o_op1, 64'h11);
        check_vec("t1a_op2", o_op2, 64'h22);
        check_vec("t1a_rd", o_rd, 64'd10);
        check_vec("t1a_pl", o_payload, 64'h1111);
        check_vec("t1a_ready", o_ready, 64'd1);
        tick();
        idle(); #1;
        check_vec("t1b_valid", o_valid, 64'd1);
        check_vec("t1b_op1", o_op1, 64'h22);
        check_vec("t1b_op2", o_op2, 64'h11);
        check_vec("t1b_pl", o_payload, 64'h2222);
        tick(); #1;
        check_vec("t1c_valid", o_valid, 64'd0);

        // 2: same-cycle write/read collision on x3.
        drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 64'h3);
        wbd(1'b1, 5'd3, 32'hAAAA);
        tick();
        idle(); wbd(1'b0, 5'd0, 32'd0); #1;
        check_vec("t2_valid", o_valid, 64'd1);
        check_vec("t2_op1", o_op1, 64'hAAAA);
        check_vec("t2_op2", o_op2, 64'd0);
        tick();

        // 3: RAW hazard on x7 resolved by write-back.
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 64'h7);
        tick();
        drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd12, 64'h8); #1;
        check_vec("t3_iss_valid", o_valid, 64'd1);
        check_vec("t3_iss_rd", o_rd, 64'd7);
        tick();
        idle(); #1;
        check_vec("t3_haz0_valid", o_valid, 64'd0);
        check_vec("t3_haz0_ready", o_ready, 64'd0);
        tick(); #1;
        check_vec("t3_haz1_valid", o_valid, 64'd0);
        wbd(1'b1, 5'd7, 32'h1234); #1;
`ifdef RV_OPFETCH_WB_BYPASS_EN
        check_vec("t3_wb_valid", o_valid, 64'd1);
        check_vec("t3_wb_op1", o_op1, 64'h1234);
`else
        check_vec("t3_wb_valid", o_valid, 64'd0);
`endif
        tick();
        wbd(1'b0, 5'd0, 32'd0); #1;
`ifdef RV_OPFETCH_WB_BYPASS_EN
        check_vec("t3_post_valid", o_valid, 64'd0);
`else
        check_vec("t3_post_valid", o_valid, 64'd1);
        check_vec("t3_post_op1", o_op1, 64'h1234);
        check_vec("t3_post_pl", o_payload, 64'h8);
`endif
        tick(); #1;
        check_vec("t3_done_valid", o_valid, 64'd0);

        // 4: stalled output picks up a write to its source.
        ready = 1'b0;
        drive(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd13, 64'h5555);
        tick();
        idle(); wbd(1'b1, 5'd5, 32'h55); #1;
        check_vec("t4_c1_valid", o_valid, 64'd1);
`ifdef RV_OPFETCH_WB_BYPASS_EN
        check_vec("t4_c1_op1", o_op1, 64'h55);
`else
        check_vec("t4_c1_op1", o_op1, 64'h11);
`endif
        check_vec("t4_c1_pl", o_payload, 64'h5555);
        for (int k = 0; k < 4; k++) begin
            tick();
            wbd(1'b0, 5'd0, 32'd0); #1;
            check_vec("t4_hold_valid", o_valid, 64'd1);
            check_vec("t4_hold_op1", o_op1, 64'h55);
            check_vec("t4_hold_op2", o_op2, 64'h22);
            check_vec("t4_hold_pl", o_payload, 64'h5555);
        end
        tick();
        ready = 1'b1; #1;
        check_vec("t4_rel_valid", o_valid, 64'd1);
        check_vec("t4_rel_op1", o_op1, 64'h55);
        tick(); #1;
        check_vec("t4_single", o_valid, 64'd0);

        // 5: flush with a hazard pending on x10 (busy since test 1).
        drive(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd14, 64'h6);
        tick();
        idle(); #1;
        check_vec("t5_haz_valid", o_valid, 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0; #1;
        check_vec("t5_flush_valid", o_valid, 64'd0);
        check_vec("t5_flush_ready", o_ready, 64'd1);
        drive(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd0, 64'h7); #1;
        check_vec("t5_acc_ready", o_ready, 64'd1);
        tick();
        idle(); #1;
        check_vec("t5_sb_kept", o_valid, 64'd0);
        wbd(1'b1, 5'd10, 32'hA0A0); #1;
`ifdef RV_OPFETCH_WB_BYPASS_EN
        check_vec("t5_wb_valid", o_valid, 64'd1);
        check_vec("t5_wb_op1", o_op1, 64'hA0A0);
`else
        check_vec("t5_wb_valid", o_valid, 64'd0);
`endif
        tick();
        wbd(1'b0, 5'd0, 32'd0); #1;
`ifdef RV_OPFETCH_WB_BYPASS_EN
        check_vec("t5_post_valid", o_valid, 64'd0);
`else
        check_vec("t5_post_valid", o_valid, 64'd1);
        check_vec("t5_post_op1", o_op1, 64'hA0A0);
        check_vec("t5_post_pl", o_payload, 64'h7);
`endif
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 64'h8);
        flush = 1'b1; #1;
        check_vec("t5_fa_ready", o_ready, 64'd1);
        tick();
        idle(); flush = 1'b0; #1;
        check_vec("t5_drop_valid", o_valid, 64'd0);

        // 6: write-back to x9 in the cycle rd=x9 issues keeps x9 busy.
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 64'h9);
        tick();
        drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 64'hA);
        wbd(1'b1, 5'd9, 32'h9A9A); #1;
        check_vec("t6_iss_valid", o_valid, 64'd1);
        check_vec("t6_iss_op1", o_op1, 64'd0);
        check_vec("t6_iss_op2", o_op2, 64'd0);
        tick();
        idle(); wbd(1'b0, 5'd0, 32'd0); #1;
        check_vec("t6_busy0", o_valid, 64'd0);
        tick(); #1;
        check_vec("t6_busy1", o_valid, 64'd0);
        wbd(1'b1, 5'd9, 32'h9B9B); #1;
`ifdef RV_OPFETCH_WB_BYPASS_EN
        check_vec("t6_wb_valid", o_valid, 64'd1);
        check_vec("t6_wb_op1", o_op1, 64'h9B9B);
`else
        check_vec("t6_wb_valid", o_valid, 64'd0);
`endif
        tick();
        wbd(1'b0, 5'd0, 32'd0); #1;
`ifdef RV_OPFETCH_WB_BYPASS_EN
        check_vec("t6_post_valid", o_valid, 64'd0);
`else
        check_vec("t6_post_valid", o_valid, 64'd1);
        check_vec("t6_post_op1", o_op1, 64'h9B9B);
`endif
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 64'hB);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 64'hC); #1;
        check_vec("t6_x0a_valid", o_valid, 64'd1);
        check_vec("t6_x0a_op1", o_op1, 64'd0);
        check_vec("t6_x0a_pl", o_payload, 64'hB);
        tick();
        idle(); #1;
        check_vec("t6_x0b_valid", o_valid, 64'd1);
        check_vec("t6_x0b_op2", o_op2, 64'd0);
        check_vec("t6_x0b_pl", o_payload, 64'hC);
        tick();

        // 7: reset mid-operation drops S1 and clears the busy mask (x13 busy since test 4).
        drive(1'b1, 5'd13, 5'd0, 1'b1, 1'b0, 5'd0, 64'hD);
        tick();
        idle(); #1;
        check_vec("t7_haz_valid", o_valid, 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        check_vec("t7_rst_valid", o_valid, 64'd0);
        check_vec("t7_rst_ready", o_ready, 64'd1);
        drive(1'b1, 5'd13, 5'd0, 1'b1, 1'b0, 5'd0, 64'hE);
        tick();
        idle(); #1;
        check_vec("t7_clr_valid", o_valid, 64'd1);
        check_vec("t7_clr_pl", o_payload, 64'hE);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
